// File: rtl/accumulator_drain_arbiter.sv
// accumulator_drain_arbiter: shares the accumulator SRAM read port between the accumulate path
// (absolute priority) and a credit-limited drain sequencer feeding a 4-entry row FIFO.
module accumulator_drain_arbiter #(
    parameter int MUL_SIZE = 32,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        acc_rd_req_i,
    input  logic [ADDR_W-1:0]           acc_rd_addr_i,
    input  logic                        drain_start_i,
    input  logic [7:0]                  drain_rows_i,
    output logic                        mem_rd_en_o,
    output logic [ADDR_W-1:0]           mem_rd_addr_o,
    input  logic [MUL_SIZE*ACC_W-1:0]   mem_rd_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [MUL_SIZE*ACC_W-1:0]   out_data_o,
    output logic                        out_last_o,
    output logic                        busy_o,
    output logic                        drain_done_o,
    output logic [15:0]                 stall_cnt_o
);
    localparam int DW = MUL_SIZE * ACC_W;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_rows, r_issue;
    logic              r_tag0_drain, r_tag0_last, r_tag1_drain, r_tag1_last;
    logic [DW-1:0]     r_mem [4];
    logic [3:0]        r_mem_last;
    logic [1:0]        r_wr, r_rd;
    logic [2:0]        r_count;
    logic [15:0]       r_stall;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;

    logic [1:0] w_inflight;
    logic       w_credit, w_want, w_drain_gnt, w_start, w_push, w_pop, w_is_last;

    // Credit counts both buffered rows and drain reads still in the tag pipe, so the FIFO cannot overflow
    assign w_inflight  = 2'(r_tag0_drain) + 2'(r_tag1_drain);
    assign w_credit    = (4'(r_count) + 4'(w_inflight)) < 4'd4;
    assign w_want      = (r_state == DRAIN) && (r_issue < r_rows) && w_credit;
    assign w_drain_gnt = w_want && !acc_rd_req_i;
    assign w_start     = (r_state == IDLE) && drain_start_i;
    assign w_push      = r_tag1_drain;
    assign w_pop       = (r_count != 3'd0) && out_ready_i;
    assign w_is_last   = r_issue == (r_rows - 8'd1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = drain_start_i ? ((drain_rows_i == 8'd0) ? DONE : DRAIN) : IDLE;
            DRAIN:   w_next = (w_drain_gnt && w_is_last) ? FLUSH : DRAIN;
            // Leave as the final row is being accepted so the done pulse lands in the following cycle
            FLUSH:   w_next = ((w_inflight == 2'd0) && ((r_count == 3'd0) || ((r_count == 3'd1) && w_pop))) ? DONE : FLUSH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_rows       <= '0;
            r_issue      <= '0;
            r_tag0_drain <= 1'b0;
            r_tag0_last  <= 1'b0;
            r_tag1_drain <= 1'b0;
            r_tag1_last  <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
            r_stall      <= '0;
            r_en         <= 1'b0;
            r_addr       <= '0;
        end else begin
            r_state      <= w_next;
            r_rows       <= w_start ? drain_rows_i : r_rows;
            r_issue      <= w_start ? 8'd0 : (w_drain_gnt ? r_issue + 8'd1 : r_issue);
            r_tag0_drain <= w_drain_gnt;
            r_tag0_last  <= w_drain_gnt && w_is_last;
            r_tag1_drain <= r_tag0_drain;
            r_tag1_last  <= r_tag0_last;
            r_wr         <= w_push ? r_wr + 2'd1 : r_wr;
            r_rd         <= w_pop ? r_rd + 2'd1 : r_rd;
            r_count      <= r_count + 3'(w_push) - 3'(w_pop);
            r_stall      <= w_start ? 16'd0 : ((w_want && acc_rd_req_i && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall);
            r_en         <= acc_rd_req_i || w_drain_gnt;
            r_addr       <= acc_rd_req_i ? acc_rd_addr_i : (w_drain_gnt ? ADDR_W'(r_issue) : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr]      <= mem_rd_data_i;
            r_mem_last[r_wr] <= r_tag1_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (!(w_push && !w_pop && r_count == 3'd4));
    end

    assign mem_rd_en_o   = r_en;
    assign mem_rd_addr_o = r_addr;
    assign out_valid_o   = r_count != 3'd0;
    assign out_data_o    = out_valid_o ? r_mem[r_rd] : '0;
    assign out_last_o    = out_valid_o && r_mem_last[r_rd];
    assign busy_o        = r_state != IDLE;
    assign drain_done_o  = r_state == DONE;
    assign stall_cnt_o   = r_stall;
endmodule

// File: tb/tb_accumulator_drain_arbiter.sv
// tb_accumulator_drain_arbiter: table-driven drain scenarios plus hand sequences for zero rows,
// ignored restart and reset mid-drain, against a simple SRAM data model.
module tb_accumulator_drain_arbiter;
    localparam int MS = 32, AW = 32, ADW = 10, DW = MS * AW;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           acc_rd_req_i = 1'b0;
    logic [ADW-1:0] acc_rd_addr_i = '0;
    logic           drain_start_i = 1'b0;
    logic [7:0]     drain_rows_i = '0;
    logic           mem_rd_en_o;
    logic [ADW-1:0] mem_rd_addr_o;
    logic [DW-1:0]  mem_rd_data_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic [DW-1:0]  out_data_o;
    logic           out_last_o;
    logic           busy_o;
    logic           drain_done_o;
    logic [15:0]    stall_cnt_o;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk_i = ~clk_i;

    accumulator_drain_arbiter #(.MUL_SIZE(MS), .ACC_W(AW), .ADDR_W(ADW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .acc_rd_req_i(acc_rd_req_i), .acc_rd_addr_i(acc_rd_addr_i),
        .drain_start_i(drain_start_i), .drain_rows_i(drain_rows_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .drain_done_o(drain_done_o),
        .stall_cnt_o(stall_cnt_o)
    );

    function automatic logic [DW-1:0] row_data(input int a);
        logic [AW-1:0] w;
        w = 32'hD000_0000 + 32'(a);
        return {MS{w}};
    endfunction

    // SRAM model: one-cycle read latency, data derived from the address
    always @(posedge clk_i) mem_rd_data_i <= mem_rd_en_o ? row_data(int'(mem_rd_addr_o)) : '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got low64 %h, expected low64 %h", name, act[63:0], exp[63:0]);
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        int rows;
        int acc_at;
        int acc_len;
        int hold;
        int restart_at;
        int exp_stall;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int t, row, drain_reads, acc_seen, pre_pop, first_en, first_val, done_at, last_acc;
        logic popped, prev_hold, prev_last;
        logic [DW-1:0] prev_data;
        row = 0; drain_reads = 0; acc_seen = 0; pre_pop = 0;
        first_en = -1; first_val = -1; done_at = -1; last_acc = -1;
        popped = 1'b0; prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
        drain_rows_i = 8'(v.rows);
        drain_start_i = 1'b1;
        out_ready_i = (v.hold == 0);
        acc_rd_req_i = 1'b0;
        step;
        chk("busy_after_start", busy_o, 1);
        t = 0;
        while (t < 700) begin
            drain_start_i = (t == v.restart_at);
            if (t == v.restart_at) drain_rows_i = 8'd9;
            acc_rd_req_i = (v.acc_at >= 0) && (t >= v.acc_at) && (t < v.acc_at + v.acc_len);
            acc_rd_addr_i = 10'h155;
            out_ready_i = (t >= v.hold);
            if (prev_hold) begin
                chk("hold_valid", out_valid_o, 1);
                chk_data("hold_data", out_data_o, prev_data);
                chk("hold_last", out_last_o, prev_last);
            end
            if (mem_rd_en_o) begin
                if (mem_rd_addr_o == 10'h155) acc_seen++;
                else begin
                    chk("drain_addr", mem_rd_addr_o, drain_reads);
                    if (first_en < 0) first_en = t;
                    if (!popped) pre_pop++;
                    drain_reads++;
                end
            end
            if (out_valid_o && first_val < 0) first_val = t;
            if (out_valid_o && out_ready_i) begin
                chk_data("row_data", out_data_o, row_data(row));
                chk("row_last", out_last_o, row == v.rows - 1);
                if (out_last_o) last_acc = t;
                row++;
                popped = 1'b1;
            end
            prev_hold = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            prev_last = out_last_o;
            if (drain_done_o) begin
                done_at = t;
                chk("busy_in_done", busy_o, 1);
                break;
            end
            step;
            t++;
        end
        chk("done_seen", done_at >= 0, 1);
        chk("done_after_last", done_at, last_acc + 1);
        chk("rows_delivered", row, v.rows);
        chk("drain_reads", drain_reads, v.rows);
        chk("acc_slots", acc_seen, v.acc_len);
        chk("stall_cnt", stall_cnt_o, v.exp_stall);
        if (v.acc_at < 0) begin
            chk("first_en_latency", first_en, 1);
            chk("first_valid_latency", first_val, 3);
        end
        if (v.hold > 0) chk("reads_before_pop", pre_pop, (v.rows < 4) ? v.rows : 4);
        drain_start_i = 1'b0;
        acc_rd_req_i = 1'b0;
        out_ready_i = 1'b1;
        step;
        chk("done_pulse_end", drain_done_o, 0);
        chk("idle_after_done", busy_o, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, mem_rd_en_o, 0);
        chk({tag, "_addr"}, mem_rd_addr_o, 0);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_last"}, out_last_o, 0);
        chk({tag, "_data_zero"}, out_data_o == '0, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, drain_done_o, 0);
        chk({tag, "_stall"}, stall_cnt_o, 0);
    endtask

    initial begin
        vec_t tv[7];
        vec_t v2;
        int delivered;
        tv[0] = '{4,   -1, 0, 0,  -1, 0};
        tv[1] = '{8,    2, 3, 0,  -1, 3};
        tv[2] = '{10,  -1, 0, 20, -1, 0};
        tv[3] = '{3,    0, 1, 0,   1, 1};
        tv[4] = '{1,   -1, 0, 0,  -1, 0};
        tv[5] = '{255, -1, 0, 0,  -1, 0};
        tv[6] = '{6,    1, 2, 8,  -1, 2};
        rst_i = 1'b1;
        step;
        step;
        chk_all_zero("reset");
        rst_i = 1'b0;
        step;
        for (int i = 0; i < 7; i++) run_vec(tv[i]);

        drain_rows_i = 8'd0;
        drain_start_i = 1'b1;
        step;
        drain_start_i = 1'b0;
        chk("zero_done", drain_done_o, 1);
        chk("zero_busy", busy_o, 1);
        chk("zero_no_read", mem_rd_en_o, 0);
        step;
        chk("zero_done_end", drain_done_o, 0);
        chk("zero_idle", busy_o, 0);
        chk("zero_no_read2", mem_rd_en_o, 0);

        drain_rows_i = 8'd16;
        drain_start_i = 1'b1;
        out_ready_i = 1'b1;
        step;
        drain_start_i = 1'b0;
        delivered = 0;
        for (int t = 0; t < 100 && delivered < 5; t++) begin
            if (out_valid_o) delivered++;
            step;
        end
        chk("rows_before_reset", delivered, 5);
        chk("busy_before_reset", busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        step;
        step;
        rst_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step;
            chk("post_rst_busy", busy_o, 0);
            chk("post_rst_done", drain_done_o, 0);
            chk("post_rst_valid", out_valid_o, 0);
        end
        v2 = '{2, -1, 0, 0, -1, 0};
        run_vec(v2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
